// File: rtl/barcode_tx_if.sv
// Handshake and serial-line bundle between a barcode_tx and whatever drives it.
// The master modport is the requester side; slave is the transmitter.
interface barcode_tx_if #(
  parameter int PERIOD_W = 22
);
  logic                send;
  logic [7:0]          ID;
  logic [PERIOD_W-1:0] period;
  logic                BC;
  logic                busy;
  logic                done;

  modport master (output send, ID, period, input BC, busy, done);
  modport slave  (input send, ID, period, output BC, busy, done);
endinterface

// File: rtl/barcode_tx.sv
// Barcode line emitter: sync cell, 8 data cells MSB first (plus parity with BC_PARITY_EN), guard cell.
// BC falls 1 clock after an accepted send; send is ignored while busy (no queueing).
module barcode_tx #(
  parameter int PERIOD_W   = 22,
  parameter int MIN_PERIOD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  barcode_tx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GUARD} state_t;

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);
`ifdef BC_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] per, per_nxt;
  logic [PERIOD_W-1:0] cell_cnt, cnt_nxt;
  logic [PERIOD_W-1:0] low_len;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [7:0]          id_sh, id_nxt;
  logic [3:0]          bit_cnt, bit_nxt;
  logic                bc_q, bc_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;
  logic                fill_bit;
  logic                cell_end;

`ifdef BC_PARITY_EN
  logic par_bit, par_nxt;
  // Parity enters the shifter from the LSB so it surfaces as the ninth shown bit.
  assign fill_bit = par_bit;
`else
  assign fill_bit = 1'b0;
`endif

  assign cnt_inc  = cell_cnt + ONE;
  assign cell_end = (cell_cnt == per - ONE);

  always_comb begin
    low_len = '0;
    case (state)
      SYNC:    low_len = per >> 1;
      DATA:    low_len = id_sh[7] ? (per >> 2) : (per - (per >> 2));
      default: low_len = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    per_nxt   = per;
    cnt_nxt   = cell_cnt;
    id_nxt    = id_sh;
    bit_nxt   = bit_cnt;
    bc_nxt    = bc_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
`ifdef BC_PARITY_EN
    par_nxt   = par_bit;
`endif
    case (state)
      IDLE: begin
        bc_nxt = 1'b1;
        if (bus.send) begin
          state_nxt = SYNC;
          per_nxt   = (bus.period < MIN_P) ? MIN_P : bus.period;
          id_nxt    = bus.ID;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          bc_nxt    = 1'b0;
          busy_nxt  = 1'b1;
`ifdef BC_PARITY_EN
          par_nxt   = ^bus.ID;
`endif
        end
      end
      default: begin
        if (!cell_end) begin
          cnt_nxt = cnt_inc;
          bc_nxt  = (cnt_inc >= low_len);
        end else begin
          // Every non-guard cell has a nonzero low phase, so a new cell always starts low.
          cnt_nxt = '0;
          bc_nxt  = 1'b0;
          case (state)
            SYNC: state_nxt = DATA;
            DATA: begin
              id_nxt = {id_sh[6:0], fill_bit};
              if (bit_cnt == LAST_BIT) begin
                state_nxt = GUARD;
                bc_nxt    = 1'b1;
              end else begin
                bit_nxt = bit_cnt + 4'd1;
              end
            end
            default: begin
              state_nxt = IDLE;
              bc_nxt    = 1'b1;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      per      <= '0;
      cell_cnt <= '0;
      id_sh    <= '0;
      bit_cnt  <= '0;
      bc_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BC_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      per      <= per_nxt;
      cell_cnt <= cnt_nxt;
      id_sh    <= id_nxt;
      bit_cnt  <= bit_nxt;
      bc_q     <= bc_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
`ifdef BC_PARITY_EN
      par_bit  <= par_nxt;
`endif
    end
  end

  assign bus.BC   = bc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
